// File: rtl/mitll_jtl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mitll_jtl_pkg
//  Purpose  : Shared defaults and a popcount helper for the toggle-encoded
//             JTL pipeline family.
//  Revision : 1.0 - initial release
// ============================================================================
package mitll_jtl_pkg;

    // Default shape of a pipeline instance
    localparam int c_DEF_W     = 4;
    localparam int c_DEF_DEPTH = 3;
    localparam int c_DEF_CNT_W = 16;

    // Widest vector the shared popcount accepts; callers zero-extend into it
    localparam int c_POP_MAX_W = 256;

    // Count of set bits in a max-width vector; a per-instance wrapper
    // zero-extends its own W-bit vector and trims the result width.
    function automatic logic [31:0] popcount(input logic [c_POP_MAX_W-1:0] vec);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < c_POP_MAX_W; i++) begin
            n = n + {31'd0, vec[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mitll_pulse_det.sv
`default_nettype none
// ============================================================================
//  Module   : mitll_pulse_det
//  Purpose  : Vector-wide toggle-to-pulse detector. The previous-input
//             register updates every edge so no transition is ever missed,
//             even while the downstream pipeline is stalled.
//  Revision : 1.0 - initial release
// ============================================================================
module mitll_pulse_det #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_in,
    output logic [W-1:0] o_det
);

    logic [W-1:0] r_in_q;

    // Remember last sampled input level, unconditionally each edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_in_q <= '0;
        else     r_in_q <= i_in;
    end

    assign o_det = i_in ^ r_in_q;

endmodule
`default_nettype wire

// File: rtl/mitll_jtlt_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : mitll_jtlt_pipe
//  Purpose  : W-channel toggle-encoded pulse pipeline of DEPTH stages with
//             stall, sticky per-channel overflow and a wrapping emitted-pulse
//             counter. Each stage bit means "pulse in flight".
//  Revision : 1.0 - initial release
// ============================================================================
module mitll_jtlt_pipe
    import mitll_jtl_pkg::*;
#(
    parameter int W     = c_DEF_W,
    parameter int DEPTH = c_DEF_DEPTH,
    parameter int CNT_W = c_DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [W-1:0]     in,
    output logic [W-1:0]     out,
    output logic [W-1:0]     ovf,
    output logic [CNT_W-1:0] pcnt
);

    logic [W-1:0]     w_det;
    logic [W-1:0]     r_stage [DEPTH];
    logic [W-1:0]     r_out;
    logic [W-1:0]     r_ovf;
    logic [CNT_W-1:0] r_pcnt;
    logic [CNT_W-1:0] w_pop;

    // Width wrapper around the shared popcount (W must not exceed c_POP_MAX_W)
    function automatic logic [CNT_W-1:0] pop_w(input logic [W-1:0] v);
        logic [c_POP_MAX_W-1:0] ext;
        ext        = '0;
        ext[W-1:0] = v;
        return CNT_W'(popcount(ext));
    endfunction

    mitll_pulse_det #(.W(W)) u_det (
        .clk   (clk),
        .rst   (rst),
        .i_in  (in),
        .o_det (w_det)
    );

    // Pulses leaving the last stage this cycle, counted for pcnt
    assign w_pop = pop_w(r_stage[DEPTH-1]);

    // Stage 0 loads on advance, accumulates while stalled; a pulse landing
    // on an occupied stalled stage 0 is dropped and flagged sticky.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage[0] <= '0;
            r_ovf      <= '0;
        end else if (en) begin
            r_stage[0] <= w_det;
        end else begin
            r_stage[0] <= r_stage[0] | w_det;
            r_ovf      <= r_ovf | (r_stage[0] & w_det);
        end
    end

    // Later stages shift only on advance
    for (genvar g = 1; g < DEPTH; g++) begin : g_stage
        always_ff @(posedge clk or posedge rst) begin
            if (rst)     r_stage[g] <= '0;
            else if (en) r_stage[g] <= r_stage[g-1];
        end
    end

    // Emit: toggle outputs and count pulses leaving the last stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out  <= '0;
            r_pcnt <= '0;
        end else if (en) begin
            r_out  <= r_out ^ r_stage[DEPTH-1];
            r_pcnt <= r_pcnt + w_pop;
        end
    end

    assign out  = r_out;
    assign ovf  = r_ovf;
    assign pcnt = r_pcnt;

endmodule
`default_nettype wire

// File: tb/tb_mitll_jtlt_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mitll_jtlt_pipe
//  Purpose  : Self-checking bench: directed scenarios plus random traffic
//             compared against an event-level pulse-flight model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mitll_jtlt_pipe;

    localparam int c_W     = 4;
    localparam int c_DEPTH = 3;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  din;
    logic [3:0]  out_a, ovf_a, out_b, ovf_b;
    logic [15:0] pcnt_a;
    logic [1:0]  pcnt_b;

    mitll_jtlt_pipe #(.W(c_W), .DEPTH(c_DEPTH), .CNT_W(16)) dut (
        .clk (clk), .rst (rst), .en (en), .in (din),
        .out (out_a), .ovf (ovf_a), .pcnt (pcnt_a)
    );

    mitll_jtlt_pipe #(.W(c_W), .DEPTH(c_DEPTH), .CNT_W(2)) dut_wrap (
        .clk (clk), .rst (rst), .en (en), .in (din),
        .out (out_b), .ovf (ovf_b), .pcnt (pcnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each pulse in flight is a (channel, advances-left) entry
    typedef struct {
        int ch;
        int rem;
    } pulse_t;

    pulse_t     pend[$];
    logic [3:0] m_prev;
    logic [3:0] m_out;
    logic [3:0] m_ovf;
    int         m_total;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    task automatic model_reset();
        pend.delete();
        m_prev  = '0;
        m_out   = '0;
        m_ovf   = '0;
        m_total = 0;
    endtask

    task automatic model_edge();
        logic [3:0] det;
        pulse_t     nq[$];
        pulse_t     p;
        bit         occ;
        det    = din ^ m_prev;
        m_prev = din;
        if (en) begin
            foreach (pend[i]) begin
                p     = pend[i];
                p.rem = p.rem - 1;
                if (p.rem == 0) begin
                    m_out[p.ch] = ~m_out[p.ch];
                    m_total++;
                end else begin
                    nq.push_back(p);
                end
            end
            for (int c = 0; c < c_W; c++) begin
                if (det[c]) nq.push_back('{c, c_DEPTH});
            end
        end else begin
            nq = pend;
            for (int c = 0; c < c_W; c++) begin
                if (det[c]) begin
                    occ = 0;
                    foreach (nq[i]) if (nq[i].ch == c && nq[i].rem == c_DEPTH) occ = 1;
                    if (occ) m_ovf[c] = 1'b1;
                    else     nq.push_back('{c, c_DEPTH});
                end
            end
        end
        pend = nq;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all();
        check("out",    {28'd0, out_a}, {28'd0, m_out});
        check("ovf",    {28'd0, ovf_a}, {28'd0, m_ovf});
        check("pcnt",   {16'd0, pcnt_a}, m_total % 65536);
        check("pcnt_w", {30'd0, pcnt_b}, m_total % 4);
    endtask

    task automatic step(input logic [3:0] nin, input logic nen);
        @(negedge clk);
        din = nin;
        en  = nen;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        din = '0;
        en  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [1:0] wrap_exp [5];
    logic [3:0] cur;

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        din = '0;
        model_reset();
        wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        // Reset state
        do_reset();

        // Basic latency on channel 0
        step(4'b0001, 1'b1);
        step(4'b0001, 1'b1);
        step(4'b0001, 1'b1);
        check("lat_out_early", {28'd0, out_a}, 32'h0);
        step(4'b0001, 1'b1);
        check("lat_out", {28'd0, out_a}, 32'h1);
        check("lat_pcnt", {16'd0, pcnt_a}, 32'd1);

        // All channels together
        step(4'b1110, 1'b1);
        repeat (3) step(4'b1110, 1'b1);
        check("all_out", {28'd0, out_a}, 32'he);
        check("all_pcnt", {16'd0, pcnt_a}, 32'd5);

        // Stall with drop on channel 1
        step(4'b1100, 1'b1);
        step(4'b1100, 1'b0);
        step(4'b1100, 1'b0);
        step(4'b1110, 1'b0);
        check("drop_ovf", {28'd0, ovf_a}, 32'h2);
        step(4'b1110, 1'b0);
        step(4'b1110, 1'b0);
        step(4'b1110, 1'b1);
        step(4'b1110, 1'b1);
        check("drop_out_hold", {28'd0, out_a}, 32'he);
        step(4'b1110, 1'b1);
        check("drop_out", {28'd0, out_a}, 32'hc);
        check("drop_pcnt", {16'd0, pcnt_a}, 32'd6);

        // Stall without drop on channel 2
        step(4'b1010, 1'b1);
        step(4'b1010, 1'b1);
        step(4'b1010, 1'b0);
        step(4'b1010, 1'b0);
        step(4'b1010, 1'b1);
        check("nodrop_hold", {28'd0, out_a}, 32'hc);
        step(4'b1010, 1'b1);
        check("nodrop_out", {28'd0, out_a}, 32'h8);
        check("nodrop_ovf", {28'd0, ovf_a}, 32'h2);

        // Random traffic
        cur = 4'b1010;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 2) != 0) cur = cur ^ 4'($urandom);
            step(cur, ($urandom_range(0, 3) != 0));
        end

        // Counter wrap on the 2-bit instance
        do_reset();
        cur = '0;
        for (int n = 0; n < 8; n++) begin
            cur[0] = ~cur[0];
            step(cur, 1'b1);
            if (n >= 3) check("wrap_seq", {30'd0, pcnt_b}, {30'd0, wrap_exp[n-3]});
        end

        // Reset in the middle of flight
        for (int n = 0; n < 3; n++) begin
            cur = ~cur;
            step(cur, 1'b1);
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        din = '0;
        model_reset();
        #1;
        check("rst_out",  {28'd0, out_a},  32'h0);
        check("rst_ovf",  {28'd0, ovf_a},  32'h0);
        check("rst_pcnt", {16'd0, pcnt_a}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 6; n++) begin
            step(4'b0000, 1'b1);
            check("post_rst_out", {28'd0, out_a}, 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
